// File: rtl/sample_ring_fifo.sv
// sample_ring_fifo: circular sample buffer with a pop/valid read port and overflow accounting.
// Define OVERWRITE_OLDEST_EN so that a write to a full buffer replaces the oldest word instead of being dropped.
module sample_ring_fifo #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 8,
  parameter int DROP_W = 16
) (
  input  logic              ref_clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic [DROP_W-1:0] drop_cnt
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic do_pop, ovf_ev, do_wr, rd_adv, grow;
  assign empty = level == '0;
  assign full  = level == DEPTH;
  always_comb begin
    do_pop = pop && !empty;
    ovf_ev = wr_valid && full && !do_pop;
`ifdef OVERWRITE_OLDEST_EN
    do_wr  = wr_valid;
    rd_adv = do_pop || ovf_ev;
`else
    do_wr  = wr_valid && !ovf_ev;
    rd_adv = do_pop;
`endif
    grow = do_wr && !ovf_ev;
  end
  always_ff @(posedge ref_clk)
    if (rst && do_wr) mem[wr_ptr] <= wr_data;
  always_ff @(posedge ref_clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pop_valid <= 1'b0;
      pop_data  <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_adv) rd_ptr <= rd_ptr + ADDR_W'(1);
      level     <= level + (ADDR_W+1)'(grow) - (ADDR_W+1)'(do_pop);
      pop_valid <= do_pop;
      if (do_pop) pop_data <= mem[rd_ptr];
      // a fresh overflow in the clearing cycle restarts the count at one
      if (ovf_ev) begin
        overflow <= 1'b1;
        drop_cnt <= clr_ovf ? DROP_W'(1) : drop_cnt + DROP_W'(!(&drop_cnt));
      end else if (clr_ovf) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sample_ring_fifo.sv
// tb_sample_ring_fifo: directed stimulus with a queue-based reference model checked every cycle.
module tb_sample_ring_fifo;
  logic        ref_clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid = 1'b0;
  logic [23:0] wr_data = '0;
  logic        pop = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        pop_valid, empty, full, overflow;
  logic [23:0] pop_data;
  logic [8:0]  level;
  logic [15:0] drop_cnt;
  int checks = 0;
  int errors = 0;

  sample_ring_fifo dut (
    .ref_clk(ref_clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
    .pop(pop), .pop_valid(pop_valid), .pop_data(pop_data), .empty(empty),
    .full(full), .level(level), .overflow(overflow), .clr_ovf(clr_ovf),
    .drop_cnt(drop_cnt)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a plain queue of stored samples
  logic [23:0] q[$];
  logic        m_pv = 1'b0;
  logic [23:0] m_pd = '0;
  logic        m_ovf = 1'b0;
  int          m_drop = 0;

  always @(posedge ref_clk) begin
    bit was_empty, was_full, popped, ev;
    if (!rst) begin
      q.delete();
      m_pv = 1'b0;
      m_pd = '0;
      m_ovf = 1'b0;
      m_drop = 0;
    end else begin
      was_empty = q.size() == 0;
      was_full = q.size() == 256;
      popped = pop && !was_empty;
      ev = 1'b0;
      m_pv = popped;
      if (popped) m_pd = q.pop_front();
      if (wr_valid) begin
        if (!was_full || popped) q.push_back(wr_data);
        else begin
          ev = 1'b1;
`ifdef OVERWRITE_OLDEST_EN
          void'(q.pop_front());
          q.push_back(wr_data);
`endif
          m_ovf = 1'b1;
          m_drop = clr_ovf ? 1 : (m_drop < 65535 ? m_drop + 1 : 65535);
        end
      end
      if (clr_ovf && !ev) begin
        m_ovf = 1'b0;
        m_drop = 0;
      end
    end
    #1;
    chk("level", 32'(level), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == 256));
    chk("pop_valid", 32'(pop_valid), 32'(m_pv));
    chk("pop_data", 32'(pop_data), 32'(m_pd));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  end

  task automatic step(input logic wv, input logic [23:0] d, input logic p, input logic c);
    wr_valid = wv;
    wr_data = d;
    pop = p;
    clr_ovf = c;
    @(posedge ref_clk);
    #2;
  endtask

  initial begin
    logic [23:0] e;
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    rst = 1'b1;
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_pop_valid", 32'(pop_valid), 0);
    // T2: three writes then three pops
    for (int i = 1; i <= 3; i++) step(1, 24'(i), 0, 0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 1, 0);
      chk("t2_pop_valid", 32'(pop_valid), 1);
      chk("t2_pop_data", 32'(pop_data), 32'(i));
    end
    step(0, 0, 0, 0);
    chk("t2_empty", 32'(empty), 1);
    chk("t2_pv_pulse", 32'(pop_valid), 0);
    // T1: reset mid-stream
    for (int i = 0; i < 5; i++) step(1, 24'(16 + i), 0, 0);
    chk("t1_level5", 32'(level), 5);
    rst = 1'b0;
    step(0, 0, 1, 0);
    rst = 1'b1;
    chk("t1_level", 32'(level), 0);
    chk("t1_empty", 32'(empty), 1);
    chk("t1_pop_valid", 32'(pop_valid), 0);
    step(0, 0, 1, 0);
    chk("t1_pop_after", 32'(pop_valid), 0);
    // T3: fill, then one write into the full buffer
    for (int i = 0; i < 256; i++) step(1, 24'(i), 0, 0);
    chk("t3_full", 32'(full), 1);
    chk("t3_level", 32'(level), 256);
    step(1, 24'hABCDEF, 0, 0);
    chk("t3_overflow", 32'(overflow), 1);
    chk("t3_drop", 32'(drop_cnt), 1);
    chk("t3_level_after", 32'(level), 256);
    for (int i = 0; i < 256; i++) begin
      step(0, 0, 1, 0);
`ifdef OVERWRITE_OLDEST_EN
      e = (i == 255) ? 24'hABCDEF : 24'(i + 1);
`else
      e = 24'(i);
`endif
      chk("t3_pop_data", 32'(pop_data), 32'(e));
    end
    chk("t3_empty", 32'(empty), 1);
    step(0, 0, 0, 1);
    chk("clr_overflow", 32'(overflow), 0);
    chk("clr_drop", 32'(drop_cnt), 0);
    // T4: write and pop together on a full buffer
    for (int i = 0; i < 256; i++) step(1, 24'(256 + i), 0, 0);
    step(1, 24'h000777, 1, 0);
    chk("t4_pop_valid", 32'(pop_valid), 1);
    chk("t4_pop_data", 32'(pop_data), 32'h100);
    chk("t4_level", 32'(level), 256);
    chk("t4_overflow", 32'(overflow), 0);
    for (int i = 0; i < 256; i++) step(0, 0, 1, 0);
    chk("t4_last", 32'(pop_data), 32'h000777);
    chk("t4_empty", 32'(empty), 1);
    // T5: write and pop together on an empty buffer
    step(1, 24'h55AA55, 1, 0);
    chk("t5_pop_valid", 32'(pop_valid), 0);
    chk("t5_level", 32'(level), 1);
    step(0, 0, 1, 0);
    chk("t5_pop_valid2", 32'(pop_valid), 1);
    chk("t5_pop_data", 32'(pop_data), 32'h55AA55);
    // T6: sustained writes with pops every third cycle, wrapping and overflowing
    for (int i = 0; i < 400; i++)
      step(1, 24'(24'h010000 + i), (i % 3) == 0, i == 390);
    chk("t6_overflow", 32'(overflow), 1);
    chk("t6_drop", 32'(drop_cnt), 32'(m_drop));
    step(0, 0, 0, 1);
    chk("t6_clr_overflow", 32'(overflow), 0);
    chk("t6_clr_drop", 32'(drop_cnt), 0);
    for (int i = 0; i < 260; i++) step(0, 0, 1, 0);
    chk("t6_empty", 32'(empty), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
